// File: rtl/hw_svm_pkg.sv
// hw_svm_pkg: shared types, state encoding and default model contents for hw_svm_core.
package hw_svm_pkg;

    localparam int N_FEAT_DEF = 4;
    localparam int DATA_W_DEF = 16;

    typedef logic signed [DATA_W_DEF-1:0] data_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_SIGN,
        ST_DONE
    } svm_state_e;

    localparam data_t WEIGHTS [N_FEAT_DEF] = '{16'sd3, -16'sd2, 16'sd1, 16'sd4};
    localparam data_t SAMPLE  [N_FEAT_DEF] = '{16'sd1, 16'sd2, 16'sd3, 16'sd1};
    localparam data_t BIAS = -16'sd5;

endpackage

// File: rtl/hw_svm_core_mac.sv
// svm_mac: signed multiply-accumulate with synchronous clear and enable.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero the accumulator on the next edge (wins over en)
//   en         : add a*b to the accumulator on the next edge
//   a, b       : signed operands
//   acc        : registered accumulator
module svm_mac #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 35
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_d, acc_q;

    always_comb begin
        prod  = a * b;
        acc_d = clr ? '0
              : en  ? acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod}
              : acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    assign acc = acc_q;

endmodule

// File: rtl/hw_svm_core.sv
// hw_svm_core: fixed-model linear SVM classifier, one MAC per clock, label on a valid/ready channel.
//   clk         : rising-edge clock
//   rst         : asynchronous active-low reset
//   start       : request one classification (honoured only in IDLE)
//   label       : 1 when w.x + b >= 0, else 0
//   label_valid : label is valid, held until accepted
//   label_ready : consumer accepts label
module hw_svm_core
    import hw_svm_pkg::*;
#(
    parameter int N_FEAT = N_FEAT_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = 2*DATA_W + $clog2(N_FEAT) + 1,
    parameter logic signed [DATA_W-1:0] W_INIT [N_FEAT] = WEIGHTS,
    parameter logic signed [DATA_W-1:0] X_INIT [N_FEAT] = SAMPLE,
    parameter logic signed [DATA_W-1:0] BIAS_P = BIAS
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic label,
    output logic label_valid,
    input  logic label_ready
);

    localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

    svm_state_e              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    label_q, label_d;
    logic                    valid_q, valid_d;
    logic                    mac_clr, mac_en;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] bias_ext;

    assign bias_ext = {{(ACC_W-DATA_W){BIAS_P[DATA_W-1]}}, BIAS_P};

    svm_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (W_INIT[idx_q]),
        .b     (X_INIT[idx_q]),
        .acc   (acc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            label_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            label_q <= label_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = start ? ST_MAC : ST_IDLE;
            ST_MAC:  state_d = (idx_q == IDX_W'(N_FEAT-1)) ? ST_SIGN : ST_MAC;
            ST_SIGN: state_d = ST_DONE;
            ST_DONE: state_d = label_ready ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Label and valid are registered here so the outputs never see an input combinationally.
    always_comb begin
        idx_d   = idx_q;
        label_d = label_q;
        valid_d = valid_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mac_clr = start;
                idx_d   = start ? '0 : idx_q;
            end
            ST_MAC: begin
                mac_en = 1'b1;
                idx_d  = idx_q + IDX_W'(1);
            end
            ST_SIGN: begin
                // Non-negative sum (including exactly zero) is class 1.
                label_d = (acc + bias_ext) >= 0;
                valid_d = 1'b1;
            end
            ST_DONE: valid_d = !label_ready;
            default: ;
        endcase
    end

    assign label       = label_q;
    assign label_valid = valid_q;

endmodule

// File: tb/tb_hw_svm_core.sv
// tb_hw_svm_core: self-checking bench for hw_svm_core across four model variants.
module tb_hw_svm_core;

    localparam int ND = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic label_ready = 1'b0;
    logic [ND-1:0] label;
    logic [ND-1:0] valid;

    int checks = 0;
    int errors = 0;
    logic [ND-1:0] exp_label;

    always #5 clk = ~clk;

    hw_svm_core u0 (
        .clk(clk), .rst(rst), .start(start),
        .label(label[0]), .label_valid(valid[0]), .label_ready(label_ready));

    hw_svm_core #(.BIAS_P(-16'sd6)) u1 (
        .clk(clk), .rst(rst), .start(start),
        .label(label[1]), .label_valid(valid[1]), .label_ready(label_ready));

    hw_svm_core #(.BIAS_P(-16'sd7)) u2 (
        .clk(clk), .rst(rst), .start(start),
        .label(label[2]), .label_valid(valid[2]), .label_ready(label_ready));

    hw_svm_core #(
        .W_INIT('{16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000}),
        .X_INIT('{16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000})
    ) u3 (
        .clk(clk), .rst(rst), .start(start),
        .label(label[3]), .label_valid(valid[3]), .label_ready(label_ready));

    function automatic longint model_f(input int w[4], input int x[4], input int b);
        longint f = longint'(b);
        for (int i = 0; i < 4; i++) f += longint'(w[i]) * longint'(x[i]);
        return f;
    endfunction

    initial begin
        int wd[4] = '{3, -2, 1, 4};
        int xd[4] = '{1, 2, 3, 1};
        int we[4] = '{-32768, -32768, -32768, -32768};
        exp_label[0] = model_f(wd, xd, -5) >= 0;
        exp_label[1] = model_f(wd, xd, -6) >= 0;
        exp_label[2] = model_f(wd, xd, -7) >= 0;
        exp_label[3] = model_f(we, we, -5) >= 0;
    end

    // Pulses start for one edge and returns the number of edges until u0 raises valid (-1 on timeout).
    task automatic start_wait(output int lat);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (valid[0]) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (valid !== '0 || label !== '0) begin
            errors++;
            $display("FAIL reset_outputs valid=%b label=%b expected 0000/0000", valid, label);
        end
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (valid !== '0) begin
            errors++;
            $display("FAIL idle_after_reset valid=%b expected 0000", valid);
        end
    endtask

    task automatic test_basic;
        int lat;
        label_ready = 1'b1;
        start_wait(lat);
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL basic_latency got %0d expected 5", lat);
        end
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (label[d] !== exp_label[d] || valid[d] !== 1'b1) begin
                errors++;
                $display("FAIL basic_label dut%0d label=%b valid=%b expected label=%b valid=1",
                         d, label[d], valid[d], exp_label[d]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid !== '0) begin
            errors++;
            $display("FAIL basic_one_cycle valid=%b expected 0000", valid);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        label_ready = 1'b0;
        for (int r = 0; r < 2; r++) begin
            start_wait(lat);
            checks++;
            if (lat != 5) begin
                errors++;
                $display("FAIL bp_latency run%0d got %0d expected 5", r, lat);
            end
            for (int c = 0; c < 10; c++) begin
                @(posedge clk);
                #1;
                checks++;
                if (valid !== '1 || label !== exp_label) begin
                    errors++;
                    $display("FAIL bp_hold run%0d cycle%0d valid=%b label=%b expected 1111/%b",
                             r, c, valid, label, exp_label);
                end
            end
            label_ready = 1'b1;
            @(posedge clk);
            #1 label_ready = 1'b0;
            checks++;
            if (valid !== '0) begin
                errors++;
                $display("FAIL bp_handshake run%0d valid=%b expected 0000", r, valid);
            end
        end
    endtask

    task automatic test_ignored_start;
        int seen;
        label_ready = 1'b0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 0;
        for (int n = 0; n < 20 && !valid[0]; n++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (valid[0] !== 1'b1 || label !== exp_label) begin
            errors++;
            $display("FAIL ign_first valid=%b label=%b expected 1/%b", valid[0], label, exp_label);
        end
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        if (valid !== '1) begin
            errors++;
            $display("FAIL ign_done_start valid=%b expected 1111", valid);
        end
        @(negedge clk);
        start = 1'b1;
        label_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        label_ready = 1'b0;
        checks++;
        if (valid !== '0) begin
            errors++;
            $display("FAIL ign_handshake valid=%b expected 0000", valid);
        end
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            #1;
            if (valid[0]) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL ign_extra_result got %0d valid cycles expected 0", seen);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        int lat;
        label_ready = 1'b1;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (valid !== '0 || label !== '0) begin
            errors++;
            $display("FAIL rstmid_async valid=%b label=%b expected 0000/0000", valid, label);
        end
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            #1;
            if (valid[0]) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rstmid_no_output got %0d valid cycles expected 0", seen);
        end
        start_wait(lat);
        checks++;
        if (lat != 5 || label !== exp_label) begin
            errors++;
            $display("FAIL rstmid_fresh lat=%0d label=%b expected 5/%b", lat, label, exp_label);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        int first;
        int second;
        first = -1;
        second = -1;
        label_ready = 1'b1;
        @(negedge clk) start = 1'b1;
        for (int n = 0; n < 30 && second < 0; n++) begin
            @(posedge clk);
            #1;
            if (valid[0] && first < 0) first = n;
            else if (valid[0] && first >= 0 && n > first + 1) second = n;
        end
        start = 1'b0;
        checks++;
        if (first != 5 || second - first != 7) begin
            errors++;
            $display("FAIL b2b_spacing first=%0d gap=%0d expected 5/7", first, second - first);
        end
        checks++;
        if (label !== exp_label) begin
            errors++;
            $display("FAIL b2b_label label=%b expected %b", label, exp_label);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        int lat;
        int hold;
        label_ready = 1'b0;
        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_wait(lat);
            checks++;
            if (lat != 5 || label !== exp_label) begin
                errors++;
                $display("FAIL rand_result it%0d lat=%0d label=%b expected 5/%b", it, lat, label, exp_label);
            end
            hold = $urandom_range(0, 6);
            for (int c = 0; c < hold; c++) begin
                start = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
                checks++;
                if (valid !== '1 || label !== exp_label) begin
                    errors++;
                    $display("FAIL rand_hold it%0d cycle%0d valid=%b label=%b", it, c, valid, label);
                end
            end
            start = 1'($urandom_range(0, 1));
            label_ready = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            label_ready = 1'b0;
            checks++;
            if (valid !== '0) begin
                errors++;
                $display("FAIL rand_handshake it%0d valid=%b expected 0000", it, valid);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_ignored_start;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
